sweep_ctrl: RTL and testbench
=============================

// Module: sweep_ctrl
// PURPOSE
//  Sequencer for the phase-accumulator counter: drives its en/incr inputs to produce a stepped frequency sweep.
//  Holds each increment for a programmable dwell, steps from start to stop, then finishes or repeats.
//  Sits between the control interface (start/abort/config) and the counter; one controller per counter.
// PARAMETERS
//  A_WIDTH      8   width of incr values; matches counter A_WIDTH
//  DWELL_WIDTH  16  width of dwell (cycles per increment value)
// PORTS
//  clk          in   1            clock, all state on rising edge
//  rst_n        in   1            asynchronous active-low reset
//  start        in   1            begin sweep; sampled only in IDLE
//  abort        in   1            stop sweep immediately, no done
//  incr_start   in   A_WIDTH      first increment value
//  incr_stop    in   A_WIDTH      final increment value (unsigned)
//  incr_step    in   A_WIDTH      amount added per dwell period
//  dwell        in   DWELL_WIDTH  cycles each value is held; 0 treated as 1
//  mode_repeat  in   1            1: wrap to incr_start after stop value's dwell
//  en           out  1            counter enable (registered)
//  incr         out  A_WIDTH      counter increment (registered)
//  busy         out  1            high whenever state != IDLE
//  done         out  1            one-cycle pulse on normal completion
// BEHAVIOUR
//  Reset: state=IDLE, en=0, incr=0, busy=0, done=0, dwell counter=0. Reset mid-sweep returns to IDLE at once.
//  States: IDLE -> RUN (start) ; RUN -> DONE (stop value dwell expired, mode_repeat=0) ; RUN -> IDLE (abort) ; DONE -> IDLE (always, 1 cycle).
//  start in IDLE: latch incr_stop, incr_step, dwell, mode_repeat, incr_start; next cycle en=1, incr=incr_start.
//  start while busy ignored; config inputs ignored outside the IDLE->RUN edge.
//  RUN: en=1; dwell counter loaded with max(dwell,1)-1, decrements each cycle; at 0 the value update occurs.
//  Value update: if incr >= stop: repeat -> incr=incr_start; else -> DONE.
//   else incr = min(incr+step, stop), sum computed at A_WIDTH+1 bits (no wrap; saturates to stop).
//  incr_start > incr_stop: one dwell at incr_start then DONE (or re-dwell at start forever if repeat).
//  step=0 with start<stop: holds incr_start until abort.
//  DONE: en=0, done=1, busy=1; incr holds last value. IDLE: en=0, incr holds.
//  abort in RUN: next cycle en=0, state IDLE, done stays 0; abort has priority over value update; ignored in IDLE/DONE.
//  Latency: start at edge k -> en/incr valid after edge k+1; done 1 cycle after last en cycle.
// CONFIGURATION
//  SWEEP_PAUSE_EN defined: extra input pause (1 bit). In RUN, pause=1 forces en=0 and freezes dwell counter and incr;
//   abort still honoured while paused. Pause ignored outside RUN.
//  SWEEP_PAUSE_EN undefined: no pause port; RUN never stalls.
// STRUCTURE
//  Package sweep_pkg: state enum typedef sweep_state_t {IDLE, RUN, DONE}; localparam DWELL_MIN = 1.
//  Sub-module dwell_timer (load, value, tick, expired): down-counter isolating dwell logic; rest stays in sweep_ctrl.
// TESTING
//  start=10,stop=30,step=8,dwell=3,repeat=0 -> incr 10,10,10,18x3,26x3,30x3 with en=1 (12 cycles), done pulse next cycle, busy low after.
//  Same config, repeat=1 -> after 30x3 incr returns to 10, no done; abort mid-dwell -> en=0 next cycle, done never pulses.
//  start=250,stop=255,step=4,dwell=0 -> incr 250,254,255 one cycle each (saturation, no wrap), then done.
//  start pulsed again during RUN with new config -> ignored, sweep unchanged; rst_n low mid-RUN -> all outputs 0 immediately.
//  incr_start=40 > incr_stop=20, dwell=2 -> incr 40 for 2 cycles then done.
//  SWEEP_PAUSE_EN: pause=1 for 5 cycles mid-dwell -> en=0, incr held, dwell resumes with remaining count.

Source files
------------

// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
//   Shared types and constants for the frequency-sweep sequencer.
//   sweep_state_t : controller state encoding (IDLE, RUN, DONE)
//   DWELL_MIN     : smallest effective dwell; a programmed dwell of 0 acts as 1
// -----------------------------------------------------------------------------
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    localparam int DWELL_MIN = 1;

endpackage

// File: rtl/dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
//   Down-counter that measures how long the current increment value is held.
//   Ports:
//     clk, rst_n  clock and asynchronous active-low reset
//     load        load 'value' into the counter (wins over tick)
//     value       reload value, i.e. dwell cycles minus one
//     tick        decrement by one (stops at zero)
//     expired     counter is zero: the current value has been held long enough
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             tick,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// -----------------------------------------------------------------------------
// sweep_ctrl
//   Sequencer for the phase-accumulator counter. Steps the counter increment
//   from incr_start towards incr_stop by incr_step, holding each value for
//   'dwell' cycles, then finishes (done pulse) or wraps back to incr_start.
//   Optional feature macro: SWEEP_PAUSE_EN adds a 'pause' input that stalls
//   the sweep while in RUN.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     start             begin a sweep (only honoured in IDLE)
//     abort             stop the sweep at once, without a done pulse
//     incr_start/stop   first and final increment values (unsigned)
//     incr_step         amount added per dwell period
//     dwell             cycles each value is held (0 behaves as 1)
//     mode_repeat       wrap to incr_start instead of finishing
//     pause             (SWEEP_PAUSE_EN only) freeze the sweep while in RUN
//     en, incr          registered counter enable and increment
//     busy              high in RUN and DONE
//     done              one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int A_WIDTH     = 8,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [A_WIDTH-1:0]     incr_start,
    input  logic [A_WIDTH-1:0]     incr_stop,
    input  logic [A_WIDTH-1:0]     incr_step,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic                   mode_repeat,
`ifdef SWEEP_PAUSE_EN
    input  logic                   pause,
`endif
    output logic                   en,
    output logic [A_WIDTH-1:0]     incr,
    output logic                   busy,
    output logic                   done
);

    sweep_state_t state_q, state_d;

    // Configuration captured on the IDLE->RUN edge
    logic [A_WIDTH-1:0]     start_q, stop_q, step_q;
    logic [DWELL_WIDTH-1:0] dwell_m1_q;
    logic                   repeat_q;

    logic [A_WIDTH-1:0]     incr_q;
    logic                   en_q;

    logic                   hold;       // RUN stalled by pause
    logic                   launch;     // start accepted this cycle
    logic                   update;     // dwell expired, value changes now
    logic                   at_stop;
    logic                   finish;
    logic                   expired;
    logic                   timer_load;
    logic [DWELL_WIDTH-1:0] dwell_m1_in;
    logic [DWELL_WIDTH-1:0] timer_value;
    logic [A_WIDTH:0]       sum;        // one extra bit so the add never wraps
    logic [A_WIDTH-1:0]     next_incr;

`ifdef SWEEP_PAUSE_EN
    assign hold = (state_q == RUN) && pause;
`else
    assign hold = 1'b0;
`endif

    assign launch  = (state_q == IDLE) && start;
    // abort outranks the value update
    assign update  = (state_q == RUN) && !abort && !hold && expired;
    assign at_stop = (incr_q >= stop_q);
    assign finish  = update && at_stop && !repeat_q;

    assign dwell_m1_in = (dwell < DWELL_WIDTH'(DWELL_MIN)) ? '0
                                                           : dwell - DWELL_WIDTH'(DWELL_MIN);

    assign sum       = {1'b0, incr_q} + {1'b0, incr_step_q_ext()};
    assign next_incr = (sum > {1'b0, stop_q}) ? stop_q : sum[A_WIDTH-1:0];

    function automatic logic [A_WIDTH-1:0] incr_step_q_ext();
        return step_q;
    endfunction

    assign timer_load  = launch || (update && !finish);
    assign timer_value = launch ? dwell_m1_in : dwell_m1_q;

    dwell_timer #(
        .WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .value   (timer_value),
        .tick    ((state_q == RUN) && !abort && !hold),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (finish) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath: configuration capture, increment sequencing, registered enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= '0;
            stop_q     <= '0;
            step_q     <= '0;
            dwell_m1_q <= '0;
            repeat_q   <= 1'b0;
            incr_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            if (launch) begin
                start_q    <= incr_start;
                stop_q     <= incr_stop;
                step_q     <= incr_step;
                dwell_m1_q <= dwell_m1_in;
                repeat_q   <= mode_repeat;
                incr_q     <= incr_start;
            end else if (update) begin
                if (at_stop) begin
                    if (repeat_q) incr_q <= start_q;
                end else begin
                    incr_q <= next_incr;
                end
            end
            en_q <= (state_d == RUN) && !hold;
        end
    end

    assign en   = en_q;
    assign incr = incr_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sweep_ctrl
//   Self-checking bench for sweep_ctrl: a table of per-cycle vectors for the
//   basic sweep (including a start re-issued mid-sweep with a different
//   configuration), then hand-written sequences for repeat/abort, saturation,
//   start>stop, zero step, asynchronous reset and (with SWEEP_PAUSE_EN) pause.
// -----------------------------------------------------------------------------
module tb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  incr_start = '0;
    logic [7:0]  incr_stop = '0;
    logic [7:0]  incr_step = '0;
    logic [15:0] dwell = '0;
    logic        mode_repeat = 1'b0;
`ifdef SWEEP_PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic        en;
    logic [7:0]  incr;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    typedef struct {
        logic        start;
        logic [7:0]  s, e, st;
        logic [15:0] d;
        logic        rpt;
        logic        x_en;
        logic [7:0]  x_incr;
        logic        x_busy;
        logic        x_done;
    } vec_t;

    vec_t vec[14];
    int   seq[12];

    sweep_ctrl #(
        .A_WIDTH     (8),
        .DWELL_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .incr_start  (incr_start),
        .incr_stop   (incr_stop),
        .incr_step   (incr_step),
        .dwell       (dwell),
        .mode_repeat (mode_repeat),
`ifdef SWEEP_PAUSE_EN
        .pause       (pause),
`endif
        .en          (en),
        .incr        (incr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st_i, input logic [7:0] s, input logic [7:0] e,
                                input logic [7:0] stp, input logic [15:0] d, input logic r,
                                input logic xe, input logic [7:0] xi, input logic xb,
                                input logic xd);
        vec_t v;
        v.start = st_i; v.s = s; v.e = e; v.st = stp; v.d = d; v.rpt = r;
        v.x_en = xe; v.x_incr = xi; v.x_busy = xb; v.x_done = xd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_out(input string nm, input logic xe, input logic [7:0] xi,
                             input logic xb, input logic xd);
        check({nm, ".en"},   32'(en),   32'(xe));
        check({nm, ".incr"}, 32'(incr), 32'(xi));
        check({nm, ".busy"}, 32'(busy), 32'(xb));
        check({nm, ".done"}, 32'(done), 32'(xd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] s, input logic [7:0] e, input logic [7:0] stp,
                           input logic [15:0] d, input logic r);
        incr_start = s; incr_stop = e; incr_step = stp; dwell = d; mode_repeat = r;
    endtask

    // Launch a sweep with the current config and check en=1 with the values in exp_q
    task automatic run_sweep(input string nm);
        start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            start = 1'b0;
            check_out($sformatf("%s[%0d]", nm, i), 1'b1, 8'(exp_q[i]), 1'b1, 1'b0);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check_out("reset", 1'b0, 8'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_out("idle_after_reset", 1'b0, 8'd0, 1'b0, 1'b0);

        // Basic sweep 10->30 step 8 dwell 3; rows after the first carry a
        // different config, and row 4 re-pulses start, all of which must be ignored
        seq = '{10, 10, 10, 18, 18, 18, 26, 26, 26, 30, 30, 30};
        vec[0] = mk(1'b1, 8'd10, 8'd30, 8'd8, 16'd3, 1'b0, 1'b1, 8'd10, 1'b1, 1'b0);
        for (int i = 1; i < 12; i++)
            vec[i] = mk(i == 4, 8'd99, 8'd200, 8'd1, 16'd7, 1'b1, 1'b1, 8'(seq[i]), 1'b1, 1'b0);
        vec[12] = mk(1'b0, 8'd99, 8'd200, 8'd1, 16'd7, 1'b1, 1'b0, 8'd30, 1'b1, 1'b1);
        vec[13] = mk(1'b0, 8'd99, 8'd200, 8'd1, 16'd7, 1'b1, 1'b0, 8'd30, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            start = vec[i].start;
            set_cfg(vec[i].s, vec[i].e, vec[i].st, vec[i].d, vec[i].rpt);
            tick();
            check_out($sformatf("basic[%0d]", i), vec[i].x_en, vec[i].x_incr,
                      vec[i].x_busy, vec[i].x_done);
        end
        start = 1'b0;

        // Repeat mode wraps to start, then abort mid-dwell
        set_cfg(8'd10, 8'd30, 8'd8, 16'd3, 1'b1);
        exp_q = '{10, 10, 10, 18, 18, 18, 26, 26, 26, 30, 30, 30, 10, 10, 10, 18};
        run_sweep("repeat");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out("abort", 1'b0, 8'd18, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("after_abort[%0d]", i), 1'b0, 8'd18, 1'b0, 1'b0);
        end

        // Saturation near the top of the range, dwell 0 acts as 1
        set_cfg(8'd250, 8'd255, 8'd4, 16'd0, 1'b0);
        exp_q = '{250, 254, 255};
        run_sweep("sat");
        tick();
        check_out("sat_done", 1'b0, 8'd255, 1'b1, 1'b1);
        tick();
        check_out("sat_idle", 1'b0, 8'd255, 1'b0, 1'b0);

        // Start above stop: one dwell at start, then done
        set_cfg(8'd40, 8'd20, 8'd8, 16'd2, 1'b0);
        exp_q = '{40, 40};
        run_sweep("rev");
        tick();
        check_out("rev_done", 1'b0, 8'd40, 1'b1, 1'b1);
        tick();
        check_out("rev_idle", 1'b0, 8'd40, 1'b0, 1'b0);

        // Zero step holds the start value until aborted
        set_cfg(8'd5, 8'd9, 8'd0, 16'd1, 1'b0);
        exp_q = '{5, 5, 5, 5, 5, 5};
        run_sweep("step0");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out("step0_abort", 1'b0, 8'd5, 1'b0, 1'b0);

        // Asynchronous reset mid-sweep clears outputs without waiting for a clock
        set_cfg(8'd10, 8'd30, 8'd8, 16'd3, 1'b0);
        exp_q = '{10, 10, 10, 18};
        run_sweep("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 8'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        check_out("post_rst", 1'b0, 8'd0, 1'b0, 1'b0);

`ifdef SWEEP_PAUSE_EN
        // Pause mid-dwell: en low, incr held, dwell resumes with remaining count
        set_cfg(8'd10, 8'd30, 8'd8, 16'd3, 1'b0);
        exp_q = '{10, 10};
        run_sweep("pre_pause");
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("paused[%0d]", i), 1'b0, 8'd10, 1'b1, 1'b0);
        end
        pause = 1'b0;
        tick();
        check_out("resume0", 1'b1, 8'd10, 1'b1, 1'b0);
        tick();
        check_out("resume1", 1'b1, 8'd18, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
